wishbone_master_burst: RTL and testbench
========================================

Name: wishbone_master_burst

Overview:
- Wishbone B4 classic/registered-feedback initiator. Converts a simple command interface (single command plus write-data stream) into read or write bursts of 1–16 words toward Wishbone slaves on the system bus.
- Used by Pocket-side logic (DMA-style copies, test engines) that need to drive the bus. Slaves such as the scratch RAM responder sit at the other end.
- Reports per-beat read data and a completion status covering ok, bus error and timeout.

Parameters:
- TIMEOUT_CYCLES, 255: cycles stb may stay high without ack or err before the transfer aborts (1..65535).
- ADDR_WIDTH, 30: word-address width of adr and req_addr.

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid&&req_ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  start word address
- req_len  in  4  beats minus one (0=1 beat, 15=16 beats)
- req_sel  in  4  byte enables applied to every beat
- wdata  in  32  write data stream
- wdata_valid  in  1  write word available
- wdata_ready  out  1  write word consumed when wdata_valid&&wdata_ready
- rdata  out  32  read data for the current beat
- rdata_valid  out  1  one-cycle pulse per read beat; no backpressure
- done  out  1  one-cycle completion pulse
- status  out  2  valid with done: 00 ok, 01 bus err, 10 timeout
- beats_done  out  5  number of beats acked, valid with done (0..16)
- cyc, stb, we  out  1 each  Wishbone cycle, strobe, write enable
- adr  out  ADDR_WIDTH  Wishbone word address
- dat_w  out  32  Wishbone write data
- sel  out  4  Wishbone byte select
- cti  out  3  cycle type identifier
- bte  out  2  burst type; constant 2'b00 (linear)
- dat_r  in  32  Wishbone read data
- ack  in  1  Wishbone acknowledge
- err  in  1  Wishbone error

Behaviour:
- Reset values: every output is 0 except req_ready, which is 1. A reset taken mid-transfer drops cyc and stb at that edge, emits no done pulse, and discards any held write word.
- State IDLE:
  - req_ready=1, cyc=0, stb=0.
  - On accept, latch addr, len, we and sel, clear the beat counter, then go to BUS (reads) or FETCH (writes).
- State FETCH (writes only):
  - cyc=1, stb=0, wdata_ready=1.
  - On a wdata handshake, load dat_w and go to BUS.
  - The timeout counter is held at 0 in this state (data underrun is a legal wait state).
- State BUS:
  - cyc=1, stb=1, adr=start+beat, we and sel latched.
  - cti: 3'b000 when len==0. Otherwise 3'b010 on every beat except the last, which uses 3'b111.
  - The timeout counter increments each cycle.
- BUS, ack (err=0) on a non-last beat:
  - Increment beat and adr (wrap modulo 2^ADDR_WIDTH); reset the timeout counter.
  - Read: rdata=dat_r and rdata_valid=1 on the next cycle; stb stays high.
  - Write: go to FETCH. stb is 0 for at least one cycle between write beats.
- BUS, ack on the last beat:
  - Read data is presented as above.
  - Go to DONE.
- BUS, err (err has priority if asserted together with ack):
  - The beat is not counted and no rdata_valid is produced.
  - Go to DONE with status 01.
- BUS timeout: when the counter reaches TIMEOUT_CYCLES, go to DONE with status 10.
- State DONE:
  - cyc=0, stb=0, done=1 for exactly one cycle with status and beats_done.
  - Return to IDLE. req_ready rises the cycle after done.
- Ack and err are ignored outside BUS. A new command never overlaps a running one.

Test Plan:
- Single read, req_addr=0x5, len=0, slave with registered ack returning adr → one stb cycle, cti=000, rdata_valid with rdata=0x5, done status=00, beats_done=1.
- 4-beat read from 0x10 → adr 0x10..0x13, cti 010,010,010,111, four rdata_valid pulses carrying 0x10..0x13, cyc held continuously, done status 00, beats_done=4.
- 3-beat write 0xA,0xB,0xC to 0x2 with wdata_valid dropped 5 cycles before beat 2 → stb low during the gap, cyc high, slave RAM[2..4]=0xA,0xB,0xC, done status 00, no timeout.
- 8-beat read, slave asserts err on beat 3 → cyc drops after err, 2 rdata_valid pulses, done status=01, beats_done=2.
- Read with TIMEOUT_CYCLES=10 and slave never acking → stb high exactly 10 cycles, then done status=10, beats_done=0.
- Reset asserted during beat 2 of a 4-beat write → cyc, stb and wdata_ready low after that edge, no done pulse, req_ready=1. A following 1-beat read to 0x3FFFFFFF completes ok; a 2-beat read there shows adr wrapping to 0.

Source files
------------

// File: rtl/wishbone_master_burst.sv
// wishbone_master_burst: turns a command plus write-data stream into Wishbone B4 bursts of 1-16 words,
// reporting read beats and a completion status (ok, bus error, timeout).
module wishbone_master_burst #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic [3:0]            req_sel,
  input  logic [31:0]           wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic [1:0]            status,
  output logic [4:0]            beats_done,
  output logic                  cyc,
  output logic                  stb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] adr,
  output logic [31:0]           dat_w,
  output logic [3:0]            sel,
  output logic [2:0]            cti,
  output logic [1:0]            bte,
  input  logic [31:0]           dat_r,
  input  logic                  ack,
  input  logic                  err
);
  typedef enum logic [1:0] {IDLE, FETCH, BUS, DONE} state_t;
  state_t state, state_n;
  logic [3:0] len_q;
  logic [4:0] beat;
  logic [15:0] tmo;
  logic [1:0] status_n;
  logic last, tmo_hit, beat_ok;
  assign last = beat[3:0] == len_q;
  assign tmo_hit = tmo == 16'(TIMEOUT_CYCLES - 1);
  assign beat_ok = state == BUS && ack && !err;
  assign req_ready = state == IDLE;
  assign wdata_ready = state == FETCH;
  assign cyc = state == FETCH || state == BUS;
  assign stb = state == BUS;
  assign done = state == DONE;
  assign beats_done = beat;
  assign bte = 2'b00;
  assign cti = !stb || len_q == 4'd0 ? 3'b000 : last ? 3'b111 : 3'b010;
  always_comb begin
    state_n = state;
    status_n = 2'b00;
    case (state)
      IDLE:  if (req_valid) state_n = req_we ? FETCH : BUS;
      FETCH: if (wdata_valid) state_n = BUS;
      BUS:
        if (err) begin
          state_n = DONE;
          status_n = 2'b01;
        end else if (ack) state_n = last ? DONE : we ? FETCH : BUS;
        else if (tmo_hit) begin
          state_n = DONE;
          status_n = 2'b10;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      beat <= '0;
      tmo <= '0;
      we <= 1'b0;
      sel <= '0;
      adr <= '0;
      dat_w <= '0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      status <= '0;
    end else begin
      state <= state_n;
      rdata_valid <= 1'b0;
      // wait time only accrues while the strobe is out; FETCH underrun is a legal stall
      tmo <= state == BUS && !ack && !err ? tmo + 16'd1 : 16'd0;
      if (state == IDLE && req_valid) begin
        adr <= req_addr;
        len_q <= req_len;
        we <= req_we;
        sel <= req_sel;
        beat <= '0;
      end
      if (state == FETCH && wdata_valid) dat_w <= wdata;
      if (beat_ok) begin
        beat <= beat + 5'd1;
        if (!last) adr <= adr + ADDR_WIDTH'(1);
        if (!we) begin
          rdata <= dat_r;
          rdata_valid <= 1'b1;
        end
      end
      if (state == BUS && state_n == DONE) status <= status_n;
    end
  end
endmodule

// File: tb/tb_wishbone_master_burst.sv
// tb_wishbone_master_burst: vector table, reset-mid-burst sequence and randomized bursts checked
// against a transfer-level model driving a registered-ack Wishbone slave.
module tb_wishbone_master_burst;
  localparam int TMO = 10;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_we = 0;
  logic [29:0] req_addr = 0;
  logic [3:0] req_len = 0, req_sel = 0;
  logic [31:0] wdata = 0;
  logic wdata_valid = 0, wdata_ready;
  logic [31:0] rdata;
  logic rdata_valid, done;
  logic [1:0] status;
  logic [4:0] beats_done;
  logic cyc, stb, we;
  logic [29:0] adr;
  logic [31:0] dat_w;
  logic [3:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  logic [31:0] dat_r = 0;
  logic ack = 0, err = 0;

  wishbone_master_burst #(.TIMEOUT_CYCLES(TMO), .ADDR_WIDTH(30)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_sel(req_sel), .wdata(wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .status(status), .beats_done(beats_done), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .dat_w(dat_w), .sel(sel), .cti(cti), .bte(bte), .dat_r(dat_r), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave: registered ack after lat extra cycles, data = address ^ key, err on response number err_beat
  int lat = 0, err_beat = 99, wcnt = 0, rcnt = 0;
  bit noack = 0;
  logic [31:0] key = 0;
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    ack <= 1'b0;
    err <= 1'b0;
    if (!cyc) begin
      wcnt <= 0;
      rcnt <= 0;
    end else if (stb && !ack && !err && !noack) begin
      if (wcnt < lat) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        rcnt <= rcnt + 1;
        if (rcnt == err_beat) err <= 1'b1;
        else begin
          ack <= 1'b1;
          dat_r <= {2'b00, adr} ^ key;
          if (we) mem[adr[7:0]] <= dat_w;
        end
      end
    end
  end

  logic [37:0] beat_q [$];
  logic [31:0] rd_q [$];
  int stb_cyc = 0, stb_rise = 0, cyc_fall = 0, done_cnt = 0, rr_at_done = 0;
  logic [1:0] st_at_done = 0;
  logic [4:0] bd_at_done = 0;
  logic prev_stb = 0, prev_cyc = 0;
  always @(negedge clk) begin
    if (stb) stb_cyc++;
    if (stb && !prev_stb) stb_rise++;
    if (prev_cyc && !cyc) cyc_fall++;
    prev_stb = stb;
    prev_cyc = cyc;
    if (stb && ack && !err) beat_q.push_back({we, sel, cti, adr});
    if (rdata_valid) rd_q.push_back(rdata);
    if (done) begin
      done_cnt++;
      st_at_done = status;
      bd_at_done = beats_done;
      rr_at_done += int'(req_ready);
    end
  end

  function automatic int model_beats(input int l, input int eb, input bit na);
    return na ? 0 : (eb <= l ? eb : l + 1);
  endfunction
  function automatic logic [1:0] model_status(input int l, input int eb, input bit na);
    return na ? 2'b10 : (eb <= l ? 2'b01 : 2'b00);
  endfunction

  bit over = 0;
  logic [31:0] wq [16];
  task automatic drive_w(input int n, input int gi, input int gl);
    for (int i = 0; i < n && !over; i++) begin
      if (i == gi) begin
        wdata_valid = 0;
        for (int k = 0; k < gl; k++) @(negedge clk);
      end
      wdata = wq[i];
      wdata_valid = 1;
      for (int t = 0; !wdata_ready && !over && t < 200; t++) @(negedge clk);
      @(negedge clk);
    end
    wdata_valid = 0;
  endtask

  task automatic run(input string tag, input logic w, input logic [29:0] a, input logic [3:0] l,
                     input logic [3:0] s, input int eb, input bit na, input int la, input int gi,
                     input int gl, input logic [1:0] es, input int ebd);
    int b0, r0, sc0, sr0, cf0, d0, rr0, n, att, t;
    logic [29:0] ai;
    logic [2:0] ce;
    n = model_beats(int'(l), eb, na);
    att = (na || eb <= int'(l)) ? n + 1 : n;
    lat = la; err_beat = eb; noack = na; over = 0;
    b0 = beat_q.size(); r0 = rd_q.size(); sc0 = stb_cyc; sr0 = stb_rise;
    cf0 = cyc_fall; d0 = done_cnt; rr0 = rr_at_done;
    req_we = w; req_addr = a; req_len = l; req_sel = s; req_valid = 1;
    for (t = 0; !req_ready && t < 50; t++) @(negedge clk);
    @(negedge clk);
    req_valid = 0;
    fork
      if (w) drive_w(int'(l) + 1, gi, gl);
      begin
        for (t = 0; done_cnt == d0 && t < 500; t++) @(negedge clk);
        over = 1;
      end
    join
    repeat (2) @(negedge clk);
    chk({tag, " done"}, done_cnt - d0, 1);
    chk({tag, " status"}, st_at_done, es);
    chk({tag, " beats_done"}, bd_at_done, ebd);
    chk({tag, " req_ready low at done"}, rr_at_done - rr0, 0);
    chk({tag, " req_ready after"}, req_ready, 1);
    chk({tag, " cyc drops"}, cyc_fall - cf0, 1);
    chk({tag, " stb rises"}, stb_rise - sr0, w ? att : 1);
    if (na) chk({tag, " stb cycles"}, stb_cyc - sc0, TMO);
    chk({tag, " acked beats"}, beat_q.size() - b0, n);
    for (int i = 0; i < n && b0 + i < beat_q.size(); i++) begin
      ai = a + 30'(i);
      ce = l == 0 ? 3'b000 : i == int'(l) ? 3'b111 : 3'b010;
      chk({tag, " beat we/sel/cti/adr"}, beat_q[b0 + i], {w, s, ce, ai});
      if (w) chk({tag, " mem"}, mem[ai[7:0]], wq[i]);
    end
    chk({tag, " rdata pulses"}, rd_q.size() - r0, w ? 0 : n);
    for (int i = 0; !w && i < n && r0 + i < rd_q.size(); i++) begin
      ai = a + 30'(i);
      chk({tag, " rdata"}, rd_q[r0 + i], {2'b00, ai} ^ key);
    end
  endtask

  typedef struct {
    logic w; logic [29:0] a; logic [3:0] l; int eb; bit na; int gi; int gl; logic [1:0] es; int ebd;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, b0, t;
    tbl[0] = '{1'b0, 30'h5, 4'd0, 99, 1'b0, 99, 0, 2'b00, 1};
    tbl[1] = '{1'b0, 30'h10, 4'd3, 99, 1'b0, 99, 0, 2'b00, 4};
    tbl[2] = '{1'b1, 30'h2, 4'd2, 99, 1'b0, 1, 5, 2'b00, 3};
    tbl[3] = '{1'b0, 30'h40, 4'd7, 2, 1'b0, 99, 0, 2'b01, 2};
    tbl[4] = '{1'b0, 30'h80, 4'd1, 99, 1'b1, 99, 0, 2'b10, 0};
    tbl[5] = '{1'b0, 30'h3FFFFFFF, 4'd0, 99, 1'b0, 99, 0, 2'b00, 1};
    tbl[6] = '{1'b0, 30'h3FFFFFFF, 4'd1, 99, 1'b0, 99, 0, 2'b00, 2};
    tbl[7] = '{1'b1, 30'h20, 4'd15, 99, 1'b0, 99, 0, 2'b00, 16};
    for (int i = 0; i < 16; i++) wq[i] = 32'hA + 32'(i);
    repeat (3) @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset outputs", {cyc, stb, we, wdata_ready, rdata_valid, done, status, beats_done, cti, bte},
        0);
    chk("reset adr/sel/dat_w/rdata", {adr, sel, dat_w, rdata}, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      run($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].l, 4'hF, tbl[i].eb, tbl[i].na, 0,
          tbl[i].gi, tbl[i].gl, tbl[i].es, tbl[i].ebd);

    d0 = done_cnt; b0 = beat_q.size();
    lat = 3; err_beat = 99; noack = 0;
    req_we = 1; req_addr = 30'h100; req_len = 3; req_sel = 4'hF; req_valid = 1;
    @(negedge clk);
    req_valid = 0; wdata = 32'h1234; wdata_valid = 1;
    for (t = 0; !(stb && beat_q.size() - b0 == 1) && t < 100; t++) @(negedge clk);
    chk("rst reached beat 2", t < 100, 1);
    reset = 1;
    @(negedge clk);
    chk("rst cyc/stb/wdata_ready/done", {cyc, stb, wdata_ready, done}, 0);
    chk("rst req_ready", req_ready, 1);
    chk("rst dat_w discarded", dat_w, 0);
    reset = 0; wdata_valid = 0;
    repeat (4) @(negedge clk);
    chk("rst no done", done_cnt - d0, 0);
    chk("rst idle", {req_ready, cyc}, 2'b10);

    for (int i = 5; i < 8; i++)
      run($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].l, 4'hF, tbl[i].eb, tbl[i].na, 0,
          tbl[i].gi, tbl[i].gl, tbl[i].es, tbl[i].ebd);

    for (int k = 0; k < 40; k++) begin
      logic w;
      logic [29:0] a;
      logic [3:0] l, s;
      int eb;
      bit na;
      w = 1'($urandom_range(0, 1));
      a = 30'($urandom);
      l = 4'($urandom_range(0, 15));
      s = 4'($urandom);
      eb = $urandom_range(0, 3) == 0 ? $urandom_range(0, int'(l)) : 99;
      na = $urandom_range(0, 9) == 0;
      if (na) eb = 99;
      key = $urandom;
      for (int i = 0; i < 16; i++) wq[i] = $urandom;
      run($sformatf("rnd%0d", k), w, a, l, s, eb, na, $urandom_range(0, 3),
          $urandom_range(0, 15), $urandom_range(0, 4), model_status(int'(l), eb, na),
          model_beats(int'(l), eb, na));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
